// File: rtl/operand_stage.sv
// Decode-to-execute operand register: resolves the three register-file read
// ports (R15 -> PC, write-port bypass), detects load-use hazards and latches
// one operand bundle per cycle with stall, flush and bubble control.
module operand_stage #(
   parameter logic [31:0] PC_OFFSET = 32'd8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   input  logic [3:0]       A_addr,
   input  logic [3:0]       B_addr,
   input  logic [3:0]       shift_addr,
   input  logic             use_A,
   input  logic             use_B,
   input  logic             use_shift,
   input  logic [31:0]      A_data,
   input  logic [31:0]      B_data,
   input  logic [31:0]      shift_data,
   input  logic [31:0]      w_data1,
   input  logic [3:0]       w_addr1,
   input  logic             w_en1,
   input  logic [31:0]      w_data2,
   input  logic [3:0]       w_addr2,
   input  logic             w_en2,
   input  logic             ex_load_valid,
   input  logic [3:0]       ex_load_rd,
   input  logic             stall,
   input  logic             flush,
   output logic             hazard,
   output logic             out_valid,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_A,
   output logic [31:0]      out_B,
   output logic [31:0]      out_shift,
   output logic [3:0]       out_A_addr,
   output logic [3:0]       out_B_addr,
   output logic [3:0]       out_shift_addr,
   output logic [CNT_W-1:0] hazard_cnt
);

   // Operand value as execute must see it: R15 reads the PC, then write
   // port 2 beats write port 1 (a dual write leaves port 2's data), then the file.
   function automatic logic [31:0] resolve(
      input logic [3:0]  addr,
      input logic [31:0] rf_data,
      input logic [31:0] pc_val,
      input logic        en1,
      input logic [3:0]  wa1,
      input logic [31:0] wd1,
      input logic        en2,
      input logic [3:0]  wa2,
      input logic [31:0] wd2
   );
      logic [31:0] v;
      if (addr == 4'd15)             v = pc_val;
      else if (en2 && (wa2 == addr)) v = wd2;
      else if (en1 && (wa1 == addr)) v = wd1;
      else                           v = rf_data;
      return v;
   endfunction

   logic             valid_q, valid_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      shift_q, shift_d;
   logic [3:0]       a_addr_q, a_addr_d;
   logic [3:0]       b_addr_q, b_addr_d;
   logic [3:0]       shift_addr_q, shift_addr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]      pc_val;
   logic [31:0]      a_res, b_res, shift_res;

   // Resolve operands and flag a load-use dependency on any operand actually read
   always_comb begin
      pc_val    = in_pc + PC_OFFSET;
      a_res     = resolve(A_addr, A_data, pc_val, w_en1, w_addr1, w_data1,
                          w_en2, w_addr2, w_data2);
      b_res     = resolve(B_addr, B_data, pc_val, w_en1, w_addr1, w_data1,
                          w_en2, w_addr2, w_data2);
      shift_res = resolve(shift_addr, shift_data, pc_val, w_en1, w_addr1, w_data1,
                          w_en2, w_addr2, w_data2);
      hazard    = in_valid && ex_load_valid &&
                  ((use_A     && (A_addr     == ex_load_rd)) ||
                   (use_B     && (B_addr     == ex_load_rd)) ||
                   (use_shift && (shift_addr == ex_load_rd)));
   end

   // Next-state selection: flush, then stall, then bubble, then capture
   always_comb begin
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      a_d          = a_q;
      b_d          = b_q;
      shift_d      = shift_q;
      a_addr_d     = a_addr_q;
      b_addr_d     = b_addr_q;
      shift_addr_d = shift_addr_q;
      cnt_d        = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (stall) begin
         valid_d = valid_q;
      end else if (hazard) begin
         valid_d = 1'b0;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
         valid_d      = in_valid;
         instr_d      = in_instr;
         pc_d         = in_pc;
         a_d          = a_res;
         b_d          = b_res;
         shift_d      = shift_res;
         a_addr_d     = A_addr;
         b_addr_d     = B_addr;
         shift_addr_d = shift_addr;
      end
   end

   // Bundle register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         shift_q      <= '0;
         a_addr_q     <= '0;
         b_addr_q     <= '0;
         shift_addr_q <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         a_q          <= a_d;
         b_q          <= b_d;
         shift_q      <= shift_d;
         a_addr_q     <= a_addr_d;
         b_addr_q     <= b_addr_d;
         shift_addr_q <= shift_addr_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_instr      = instr_q;
   assign out_pc         = pc_q;
   assign out_A          = a_q;
   assign out_B          = b_q;
   assign out_shift      = shift_q;
   assign out_A_addr     = a_addr_q;
   assign out_B_addr     = b_addr_q;
   assign out_shift_addr = shift_addr_q;
   assign hazard_cnt     = cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: the driver pushes hand-computed
// expected bundles, a monitor pops and compares one per cycle.
module tb_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr, in_pc;
   logic [3:0]  A_addr, B_addr, shift_addr;
   logic        use_A, use_B, use_shift;
   logic [31:0] A_data, B_data, shift_data;
   logic [31:0] w_data1, w_data2;
   logic [3:0]  w_addr1, w_addr2;
   logic        w_en1, w_en2;
   logic        ex_load_valid;
   logic [3:0]  ex_load_rd;
   logic        stall, flush;

   logic        hazard, out_valid;
   logic [31:0] out_instr, out_pc, out_A, out_B, out_shift;
   logic [3:0]  out_A_addr, out_B_addr, out_shift_addr;
   logic [15:0] hazard_cnt;

   logic        d2_hazard, d2_valid;
   logic [31:0] d2_instr, d2_pc, d2_A, d2_B, d2_shift;
   logic [3:0]  d2_A_addr, d2_B_addr, d2_shift_addr;
   logic [1:0]  d2_cnt;

   always #5 clk = ~clk;

   operand_stage #(.PC_OFFSET(32'd8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
      .use_A(use_A), .use_B(use_B), .use_shift(use_shift),
      .A_data(A_data), .B_data(B_data), .shift_data(shift_data),
      .w_data1(w_data1), .w_addr1(w_addr1), .w_en1(w_en1),
      .w_data2(w_data2), .w_addr2(w_addr2), .w_en2(w_en2),
      .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
      .stall(stall), .flush(flush), .hazard(hazard), .out_valid(out_valid),
      .out_instr(out_instr), .out_pc(out_pc), .out_A(out_A), .out_B(out_B),
      .out_shift(out_shift), .out_A_addr(out_A_addr), .out_B_addr(out_B_addr),
      .out_shift_addr(out_shift_addr), .hazard_cnt(hazard_cnt)
   );

   operand_stage #(.PC_OFFSET(32'd8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
      .use_A(use_A), .use_B(use_B), .use_shift(use_shift),
      .A_data(A_data), .B_data(B_data), .shift_data(shift_data),
      .w_data1(w_data1), .w_addr1(w_addr1), .w_en1(w_en1),
      .w_data2(w_data2), .w_addr2(w_addr2), .w_en2(w_en2),
      .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
      .stall(stall), .flush(flush), .hazard(d2_hazard), .out_valid(d2_valid),
      .out_instr(d2_instr), .out_pc(d2_pc), .out_A(d2_A), .out_B(d2_B),
      .out_shift(d2_shift), .out_A_addr(d2_A_addr), .out_B_addr(d2_B_addr),
      .out_shift_addr(d2_shift_addr), .hazard_cnt(d2_cnt)
   );

   typedef struct {
      logic        v;
      logic [31:0] instr, pc, a, b, s;
      logic [11:0] addrs;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic expect_out(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                             input logic [11:0] addrs, input logic [15:0] cnt,
                             input logic [1:0] cnt2);
      exp_t e;
      e.v = v; e.instr = instr; e.pc = pc; e.a = a; e.b = b; e.s = s;
      e.addrs = addrs; e.cnt = cnt; e.cnt2 = cnt2;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      in_valid = 0; in_instr = '0; in_pc = '0;
      A_addr = '0; B_addr = '0; shift_addr = '0;
      use_A = 0; use_B = 0; use_shift = 0;
      A_data = '0; B_data = '0; shift_data = '0;
      w_data1 = '0; w_addr1 = '0; w_en1 = 0;
      w_data2 = '0; w_addr2 = '0; w_en2 = 0;
      ex_load_valid = 0; ex_load_rd = '0; stall = 0; flush = 0;
   endtask

   // Monitor: one expected bundle per cycle, sampled 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
            chk("out_instr", out_instr, e.instr);
            chk("out_pc", out_pc, e.pc);
            chk("out_A", out_A, e.a);
            chk("out_B", out_B, e.b);
            chk("out_shift", out_shift, e.s);
            chk("out_addrs", {20'd0, out_A_addr, out_B_addr, out_shift_addr}, {20'd0, e.addrs});
            chk("hazard_cnt", {16'd0, hazard_cnt}, {16'd0, e.cnt});
            chk("hazard_cnt_w2", {30'd0, d2_cnt}, {30'd0, e.cnt2});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst = 0;
      #1 rst = 1;
      #1;
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_A", out_A, 32'd0);
      chk("reset_instr", out_instr, 32'd0);
      chk("reset_cnt", {16'd0, hazard_cnt}, 32'd0);
      chk("reset_cnt_w2", {30'd0, d2_cnt}, 32'd0);
      step();
      rst = 0;

      // dual write to the same register: port 2 wins
      in_valid = 1; in_instr = 32'h11111111; in_pc = 32'h100;
      A_addr = 3; A_data = 32'h11; B_addr = 4; B_data = 32'h44;
      shift_addr = 0; shift_data = 32'h55;
      w_en1 = 1; w_addr1 = 3; w_data1 = 32'h22;
      w_en2 = 1; w_addr2 = 3; w_data2 = 32'h33;
      #1 chk("hazard_bypass", {31'd0, hazard}, 32'd0);
      expect_out(1, 32'h11111111, 32'h100, 32'h33, 32'h44, 32'h55, {4'd3, 4'd4, 4'd0}, 0, 0);
      step();

      // port 1 only
      w_en2 = 0; in_instr = 32'h22222222;
      expect_out(1, 32'h22222222, 32'h100, 32'h22, 32'h44, 32'h55, {4'd3, 4'd4, 4'd0}, 0, 0);
      step();

      // R15 reads PC+8 and ignores a write to R15
      w_addr1 = 15; w_data1 = 32'hDEAD; B_addr = 15; in_pc = 32'h1000;
      in_instr = 32'h33333333;
      expect_out(1, 32'h33333333, 32'h1000, 32'h11, 32'h1008, 32'h55, {4'd3, 4'd15, 4'd0}, 0, 0);
      step();

      // PC+8 wraps
      in_pc = 32'hFFFFFFFC; in_instr = 32'h44444444;
      expect_out(1, 32'h44444444, 32'hFFFFFFFC, 32'h11, 32'h4, 32'h55, {4'd3, 4'd15, 4'd0}, 0, 0);
      step();

      // R15 also ignores port 2
      in_pc = 32'h1000; shift_addr = 15; w_en2 = 1; w_addr2 = 15; w_data2 = 32'hBEEF;
      in_instr = 32'h55555555;
      expect_out(1, 32'h55555555, 32'h1000, 32'h11, 32'h1008, 32'h1008, {4'd3, 4'd15, 4'd15}, 0, 0);
      step();

      // load-use on the shift operand -> bubble
      w_en1 = 0; w_en2 = 0; ex_load_valid = 1; ex_load_rd = 5;
      use_shift = 1; shift_addr = 5; in_instr = 32'h66666666; in_pc = 32'h3000;
      B_addr = 4;
      #1 chk("hazard_loaduse", {31'd0, hazard}, 32'd1);
      expect_out(0, 32'h55555555, 32'h1000, 32'h11, 32'h1008, 32'h1008, {4'd3, 4'd15, 4'd15}, 1, 1);
      step();

      // same addresses, shift not used -> captures
      use_shift = 0;
      #1 chk("hazard_unused", {31'd0, hazard}, 32'd0);
      expect_out(1, 32'h66666666, 32'h3000, 32'h11, 32'h44, 32'h55, {4'd3, 4'd4, 4'd5}, 1, 1);
      step();

      // dependency but in_valid=0: no hazard, dead bundle still captures fields
      in_valid = 0; use_A = 1; A_addr = 5; in_instr = 32'h77777777;
      #1 chk("hazard_invalid", {31'd0, hazard}, 32'd0);
      expect_out(0, 32'h77777777, 32'h3000, 32'h11, 32'h44, 32'h55, {4'd5, 4'd4, 4'd5}, 1, 1);
      step();

      // load to R15 compared like any register
      in_valid = 1; ex_load_rd = 15; use_A = 0; use_B = 1; B_addr = 15;
      in_instr = 32'h88888888;
      #1 chk("hazard_rd15", {31'd0, hazard}, 32'd1);
      expect_out(0, 32'h77777777, 32'h3000, 32'h11, 32'h44, 32'h55, {4'd5, 4'd4, 4'd5}, 2, 2);
      step();

      // capture the bundle that will be stalled
      idle();
      in_valid = 1; in_instr = 32'hE0810002; in_pc = 32'h2000;
      A_addr = 1; A_data = 32'hA1; B_addr = 2; B_data = 32'hB2; shift_data = 32'h55;
      expect_out(1, 32'hE0810002, 32'h2000, 32'hA1, 32'hB2, 32'h55, {4'd1, 4'd2, 4'd0}, 2, 2);
      step();

      // stall holds everything, hazard visible but not counted
      stall = 1; in_instr = 32'hBAD0BAD0; A_data = 32'hFF;
      ex_load_valid = 1; ex_load_rd = 1; use_A = 1;
      w_en1 = 1; w_addr1 = 1; w_data1 = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         #1 chk("hazard_stall", {31'd0, hazard}, 32'd1);
         expect_out(1, 32'hE0810002, 32'h2000, 32'hA1, 32'hB2, 32'h55, {4'd1, 4'd2, 4'd0}, 2, 2);
         step();
      end

      // flush beats stall
      flush = 1;
      expect_out(0, 32'hE0810002, 32'h2000, 32'hA1, 32'hB2, 32'h55, {4'd1, 4'd2, 4'd0}, 2, 2);
      step();

      // asynchronous reset between edges
      idle();
      #1 rst = 1;
      #1;
      chk("midreset_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset_A", out_A, 32'd0);
      chk("midreset_instr", out_instr, 32'd0);
      chk("midreset_cnt", {16'd0, hazard_cnt}, 32'd0);
      chk("midreset_cnt_w2", {30'd0, d2_cnt}, 32'd0);
      #1 rst = 0;

      // five consecutive bubbles: 2-bit counter saturates at 3
      in_valid = 1; ex_load_valid = 1; ex_load_rd = 7; use_B = 1; B_addr = 7;
      B_data = 32'h99; in_instr = 32'h99999999;
      for (int i = 1; i <= 5; i++) begin
         #1 chk("hazard_sat", {31'd0, hazard}, 32'd1);
         expect_out(0, '0, '0, '0, '0, '0, '0, 16'(i), (i < 3) ? 2'(i) : 2'd3);
         step();
      end

      // flush beats hazard: no bubble counted
      flush = 1;
      expect_out(0, '0, '0, '0, '0, '0, '0, 16'd5, 2'd3);
      step();

      // load leaves execute: hazard clears and the instruction captures
      flush = 0; ex_load_valid = 0;
      #1 chk("hazard_clear", {31'd0, hazard}, 32'd0);
      expect_out(1, 32'h99999999, 32'h0, 32'h0, 32'h99, 32'h0, {4'd0, 4'd7, 4'd0}, 16'd5, 2'd3);
      step();

      step();
      chk("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode-to-execute pipeline register that consumes the register file's three combinational read ports (A, B, shift).
- Applies same-cycle write-port bypass, because file writes land only at the clock edge.
- Substitutes the architectural PC value for R15 reads and detects load-use hazards.
- Latches one operand bundle per cycle for the execute stage, with stall, flush and bubble insertion.

Parameters:
PC_OFFSET, 8, value added to in_pc when any operand address is 15
CNT_W, 16, width of saturating hazard-bubble counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  decode presents a valid instruction
in_instr  input  32  instruction word
in_pc  input  32  address of in_instr
A_addr / B_addr / shift_addr  input  4 each  operand register numbers, also driven to the register file
use_A / use_B / use_shift  input  1 each  operand is actually read by the instruction
A_data / B_data / shift_data  input  32 each  register file read data
w_data1, w_addr1, w_en1  input  32/4/1  snooped write port 1
w_data2, w_addr2, w_en2  input  32/4/1  snooped write port 2
ex_load_valid  input  1  execute stage holds a load not yet written back
ex_load_rd  input  4  destination of that load
stall  input  1  downstream hold
flush  input  1  branch/exception squash
hazard  output  1  combinational; decode must hold its current instruction
out_valid  output  1  latched bundle valid
out_instr, out_pc  output  32 each  latched instruction and PC
out_A, out_B, out_shift  output  32 each  latched resolved operands
out_A_addr, out_B_addr, out_shift_addr  output  4 each  latched operand addresses
hazard_cnt  output  CNT_W  count of inserted bubbles, saturating

Behaviour:
- Reset (async, rst=1): all outputs and registers are 0, including out_valid and hazard_cnt. Deasserting rst mid-operation resumes from that empty state.
- Operand resolution (combinational, per operand, in priority order):
  - addr==15: value is in_pc+PC_OFFSET, mod 2^32; R15 is never bypassed.
  - Else w_en2 && w_addr2==addr: value is w_data2. Port 2 beats port 1 because a dual write to one address leaves port 2's data.
  - Else w_en1 && w_addr1==addr: value is w_data1.
  - Else the register file data.
- hazard = in_valid && ex_load_valid && any of (use_A && A_addr==ex_load_rd), (use_B && B_addr==ex_load_rd), (use_shift && shift_addr==ex_load_rd). Unused operands never raise hazard. rd=15 is compared like any other register.
- Edge update, first matching row wins:
  1. flush: out_valid<=0, all other outputs hold; flush wins over stall and hazard.
  2. stall: all outputs hold; hazard may still assert but no bubble is counted.
  3. hazard: bubble, out_valid<=0; hazard_cnt+=1, saturating at all-ones.
  4. Otherwise: capture out_valid<=in_valid and all resolved fields. Fields capture even when in_valid=0, and out_valid=0 marks the bundle dead.
- Latency: exactly 1 cycle from operand presentation to out_*.
- A held bundle (stall) keeps the operands it latched. It does not re-snoop write ports; later writes are the forwarding unit's job in execute.
- hazard clears the cycle after the bubble, when the load leaves execute (ex_load_valid drops).

Test Plan:
- Reset mid-stream: rst pulsed asynchronously between edges -> out_valid, out_A, hazard_cnt read 0 immediately, not at the next edge.
- Dual bypass: A_addr=3, A_data=0x11, w_en1 with addr 3/data 0x22, w_en2 with addr 3/data 0x33 -> out_A=0x33 after the edge. With w_en2=0 -> out_A=0x22.
- PC read: B_addr=15, in_pc=0x1000, w_en1 addr 15/data 0xDEAD -> out_B=0x1008. With in_pc=0xFFFFFFFC -> out_B=0x00000004.
- Load-use: ex_load_valid=1, ex_load_rd=5, use_shift=1, shift_addr=5, in_valid=1 -> hazard=1, next out_valid=0, hazard_cnt=1. Same case with use_shift=0 -> hazard=0 and the bundle captures.
- Stall/flush priority: out_valid=1 with instr 0xE0810002. stall=1 for 3 cycles -> outputs unchanged, hazard_cnt unchanged despite hazard=1. stall=1 with flush=1 -> out_valid=0 next edge.
- Saturation: CNT_W=2, 5 consecutive hazard bubbles -> hazard_cnt sequence 1,2,3,3,3.
